// File: rtl/integer_file_write_arbiter_pkg.sv
// Shared types and defaults for the integer register file write-port arbiter.
// Holds the late-result entry layout plus DEPTH/STARVE_LIMIT defaults.
package integer_file_write_arbiter_pkg;

  localparam int unsigned DEPTH_DEF        = 2;
  localparam int unsigned STARVE_LIMIT_DEF = 3;
  localparam logic [4:0]  X0_ADDR          = 5'd0;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } late_entry_t;

  // x0 is hardwired zero, so it never takes part in writes or hazards
  function automatic logic is_real_reg(input logic [4:0] addr);
    return (addr != X0_ADDR);
  endfunction

endpackage

// File: rtl/integer_file_write_arbiter_fifo.sv
// Synchronous FIFO buffering late results until the write port is free.
// Flags are derived from registered occupancy only.
module late_result_fifo
  import integer_file_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  logic        pop_i,
  input  late_entry_t entry_i,
  output late_entry_t entry_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  late_entry_t   mem_q [DEPTH];
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == {CW{1'b0}});
  assign push_ok_s = push_i & ~full_o;
  assign pop_ok_s  = pop_i & ~empty_o;
  assign entry_o   = mem_q[rd_ptr_q];

  // Next pointers and occupancy; power-of-2 depth makes pointer wrap free
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care while unoccupied
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= entry_i;
    end
  end

endmodule

// File: rtl/integer_file_write_arbiter.sv
// Arbitrates the integer register file write port between stage 3 writeback and
// buffered late results, and tracks destinations with outstanding late results.
module integer_file_write_arbiter
  import integer_file_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH        = DEPTH_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb_en_i,
  input  logic [4:0]  wb_addr_i,
  input  logic [31:0] wb_data_i,
  input  logic        late_valid_i,
  output logic        late_ready_o,
  input  logic [4:0]  late_addr_i,
  input  logic [31:0] late_data_i,
  input  logic        issue_late_i,
  input  logic [4:0]  issue_addr_i,
  output logic        issue_hazard_o,
  input  logic [4:0]  rs_1_addr_i,
  input  logic [4:0]  rs_2_addr_i,
  output logic        rs_hazard_o,
  output logic        pipe_stall_o,
  output logic [4:0]  rd_addr_o,
  output logic        wr_en_o,
  output logic [31:0] rd_o
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  late_entry_t head_s;
  logic        full_s, empty_s;
  logic        push_s, head_grant_s, wb_wins_s;
  logic [31:0] pending_q, pending_d;
  logic [3:0]  starve_q, starve_d;

  assign late_ready_o = ~full_s;
  assign push_s       = late_valid_i & ~full_s & is_real_reg(late_addr_i);
  assign wb_wins_s    = wb_en_i & is_real_reg(wb_addr_i);
  assign head_grant_s = ~wb_wins_s & ~empty_s;

  late_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_s),
    .pop_i   (head_grant_s),
    .entry_i ('{addr: late_addr_i, data: late_data_i}),
    .entry_o (head_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // Write-port grant: stage 3 first, then the FIFO head, else idle
  always_comb begin
    wr_en_o   = 1'b0;
    rd_addr_o = X0_ADDR;
    rd_o      = 32'd0;
    if (wb_wins_s) begin
      wr_en_o   = 1'b1;
      rd_addr_o = wb_addr_i;
      rd_o      = wb_data_i;
    end else if (head_grant_s) begin
      wr_en_o   = 1'b1;
      rd_addr_o = head_s.addr;
      rd_o      = head_s.data;
    end else begin
      wr_en_o   = 1'b0;
    end
  end

  // Scoreboard: clear on head retire, then set on issue so set wins a collision
  always_comb begin
    pending_d = pending_q;
    if (head_grant_s) begin
      pending_d[head_s.addr] = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    if (issue_late_i && is_real_reg(issue_addr_i)) begin
      pending_d[issue_addr_i] = 1'b1;
    end else begin
      pending_d[0] = pending_d[0];
    end
    pending_d[0] = 1'b0;
  end

  assign rs_hazard_o    = (is_real_reg(rs_1_addr_i) & pending_q[rs_1_addr_i]) |
                          (is_real_reg(rs_2_addr_i) & pending_q[rs_2_addr_i]);
  assign issue_hazard_o = is_real_reg(issue_addr_i) & pending_q[issue_addr_i];

  // Starvation: count denied cycles of a waiting head, saturating at the limit
  always_comb begin
    starve_d = starve_q;
    if (empty_s || head_grant_s) begin
      starve_d = 4'd0;
    end else if (starve_q < LIMIT) begin
      starve_d = starve_q + 4'd1;
    end else begin
      starve_d = starve_q;
    end
  end

  assign pipe_stall_o = (starve_q == LIMIT);

  // State registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q <= 32'd0;
      starve_q  <= 4'd0;
    end else begin
      pending_q <= pending_d;
      starve_q  <= starve_d;
    end
  end

endmodule
